// File: rtl/tsbus_pkg.sv
// -----------------------------------------------------------------------------
// tsbus_pkg
// Shared definitions for the three-state bus arbiter and the bus-user benches:
//   - tsbus_state_e : arbiter FSM state encoding
//   - TSBUS_MAX_HOLD_DEF / TSBUS_TURN_CYCLES_DEF : default hold limit and
//     turnaround length
//   - tsbus_own_w() : owner index width for a given user count
// -----------------------------------------------------------------------------
package tsbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } tsbus_state_e;

  localparam int TSBUS_MAX_HOLD_DEF    = 8;
  localparam int TSBUS_TURN_CYCLES_DEF = 1;

  // Width of an index able to address n_users entries (never below 1 bit).
  function automatic int tsbus_own_w(input int n_users);
    return (n_users > 1) ? $clog2(n_users) : 1;
  endfunction

endpackage : tsbus_pkg

// File: rtl/tsbus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches req_i for the first set bit
// starting at index rr_i and wrapping modulo N_USERS.
//   req_i   [N_USERS-1:0] : request vector
//   rr_i    [OWN_W-1:0]   : highest-priority index (must be < N_USERS)
//   valid_o               : at least one request is set
//   idx_o   [OWN_W-1:0]   : selected index (0 when valid_o is low)
// -----------------------------------------------------------------------------
module rr_pick
  import tsbus_pkg::*;
#(
  parameter int N_USERS = 2,
  parameter int OWN_W   = tsbus_own_w(N_USERS)
) (
  input  logic [N_USERS-1:0] req_i,
  input  logic [OWN_W-1:0]   rr_i,
  output logic               valid_o,
  output logic [OWN_W-1:0]   idx_o
);

  // One extra bit so rr_i + offset never overflows before the wrap.
  logic [OWN_W:0]   pos_w;
  logic [OWN_W-1:0] pos;

  // Scan from the farthest offset down to offset 0, so the last hit written
  // is the one closest to rr_i.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    pos_w   = '0;
    pos     = '0;
    for (int k = N_USERS - 1; k >= 0; k--) begin
      pos_w = {1'b0, rr_i} + (OWN_W + 1)'(k);
      if (pos_w >= (OWN_W + 1)'(N_USERS)) begin
        pos_w = pos_w - (OWN_W + 1)'(N_USERS);
      end
      pos = pos_w[OWN_W-1:0];
      if (req_i[pos]) begin
        valid_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule : rr_pick

// File: rtl/tsbus_arbiter.sv
// -----------------------------------------------------------------------------
// tsbus_arbiter
// Round-robin owner of the enable lines on a shared three-state bus. Grants
// are one-hot-or-zero and registered, separated by TURN_CYCLES idle cycles,
// and an owner is forced off after MAX_HOLD cycles if someone else waits.
//
// State table:
//   state | meaning
//   IDLE  | no owner; arbitrate every edge, grant low
//   GRANT | owner drives the bus; hold counter runs
//   TURN  | turnaround, all grants low; arbitrate on the last turn cycle
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous reset, active low
//   req       [N_USERS-1:0] : per-user level request
//   grant     [N_USERS-1:0] : registered one-hot-or-zero enable per user
//   bus_busy  : registered OR of grant
//   owner     [OWN_W-1:0]   : index of current/last granted user
//   turn      : high during turnaround cycles
// -----------------------------------------------------------------------------
module tsbus_arbiter
  import tsbus_pkg::*;
#(
  parameter int N_USERS     = 2,
  parameter int MAX_HOLD    = TSBUS_MAX_HOLD_DEF,
  parameter int TURN_CYCLES = TSBUS_TURN_CYCLES_DEF,
  parameter int OWN_W       = tsbus_own_w(N_USERS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_USERS-1:0] req,
  output logic [N_USERS-1:0] grant,
  output logic               bus_busy,
  output logic [OWN_W-1:0]   owner,
  output logic               turn
);

  // With MAX_HOLD = 0 the hold counter is never consulted; it still needs a
  // legal width and saturation point.
  localparam int HOLD_SAT = (MAX_HOLD > 0) ? MAX_HOLD : 1;
  localparam int HOLD_W   = $clog2(HOLD_SAT + 1);
  localparam int TC_W     = $clog2(TURN_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_SAT_V = HOLD_W'(HOLD_SAT);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
  localparam logic [TC_W-1:0]   TC_INIT    = TC_W'(TURN_CYCLES);
  localparam logic [TC_W-1:0]   TC_ONE     = TC_W'(1);
  localparam logic [OWN_W-1:0]  OWN_LAST   = OWN_W'(N_USERS - 1);
  localparam logic [OWN_W-1:0]  OWN_ONE    = OWN_W'(1);

  tsbus_state_e        state_q, state_d;
  logic [N_USERS-1:0]  grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [OWN_W-1:0]    rr_q, rr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TC_W-1:0]     tcnt_q, tcnt_d;
  logic                turn_q, turn_d;

  logic                pick_valid;
  logic [OWN_W-1:0]    pick_idx;
  logic                owner_req;
  logic                others_req;
  logic                hold_expired;

  rr_pick #(
    .N_USERS (N_USERS),
    .OWN_W   (OWN_W)
  ) u_rr_pick (
    .req_i   (req),
    .rr_i    (rr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign owner_req    = req[owner_q];
  // grant_q is one-hot on the owner while in GRANT, so masking it leaves only
  // competing requests.
  assign others_req   = |(req & ~grant_q);
  assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_SAT_V) && others_req;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    tcnt_d  = tcnt_q;
    turn_d  = turn_q;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        turn_d  = 1'b0;
        if (pick_valid) begin
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          hold_d            = HOLD_ONE;
          state_d           = GRANT;
        end
      end

      GRANT: begin
        if (hold_q < HOLD_SAT_V) begin
          hold_d = hold_q + HOLD_ONE;
        end
        if (!owner_req || hold_expired) begin
          grant_d = '0;
          rr_d    = (owner_q == OWN_LAST) ? '0 : owner_q + OWN_ONE;
          turn_d  = 1'b1;
          tcnt_d  = TC_INIT;
          state_d = TURN;
        end
      end

      TURN: begin
        grant_d = '0;
        if (tcnt_q <= TC_ONE) begin
          // Last turnaround cycle: arbitrate now so the next owner's grant
          // rises right after the gap, not one cycle later.
          turn_d = 1'b0;
          tcnt_d = '0;
          if (pick_valid) begin
            grant_d[pick_idx] = 1'b1;
            owner_d           = pick_idx;
            hold_d            = HOLD_ONE;
            state_d           = GRANT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tcnt_d = tcnt_q - TC_ONE;
        end
      end

      default: begin
        grant_d = '0;
        turn_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy_d = |grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      tcnt_q  <= '0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      tcnt_q  <= tcnt_d;
      turn_q  <= turn_d;
    end
  end

  assign grant    = grant_q;
  assign bus_busy = busy_q;
  assign owner    = owner_q;
  assign turn     = turn_q;

endmodule : tsbus_arbiter
